// File: rtl/hamming_input_capture.sv
// ============================================================================
// Module      : hamming_input_capture
// Description : User-input front end for the Hamming demo board. Synchronizes
//               all raw switches/buttons, debounces the load and select
//               buttons, captures the data and error-position switches on an
//               accepted load press, and keeps the display-select level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_input_capture #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_data,
    input  logic [2:0] sw_err,
    input  logic       btn_load,
    input  logic       btn_sel,
    output logic [3:0] data_word,
    output logic [2:0] err_pos,
    output logic       load_pulse,
    output logic       disp_sel,
    output logic       busy
);

    // Counter value at which a differing level has been held long enough.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // Button index map inside the button vectors.
    localparam int c_BTN_LOAD = 0;
    localparam int c_BTN_SEL  = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    logic [3:0] r_data_s1, r_data_s2;
    logic [2:0] r_err_s1,  r_err_s2;
    logic [1:0] r_btn_s1,  r_btn_s2;

    // Bring every asynchronous input into the clk domain before use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_s1 <= '0;
            r_data_s2 <= '0;
            r_err_s1  <= '0;
            r_err_s2  <= '0;
            r_btn_s1  <= '0;
            r_btn_s2  <= '0;
        end else begin
            r_data_s1 <= sw_data;
            r_data_s2 <= r_data_s1;
            r_err_s1  <= sw_err;
            r_err_s2  <= r_err_s1;
            r_btn_s1  <= {btn_sel, btn_load};
            r_btn_s2  <= r_btn_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers, one per button
    // ------------------------------------------------------------------
    logic w_stable [2];
    logic w_rise   [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic             r_stable;
            logic             r_stable_d;
            logic [CNT_W-1:0] r_cnt;

            // Accept a new level only after it has differed from the
            // stable level for DEBOUNCE_CYCLES consecutive cycles.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_stable_d <= r_stable;
                    if (r_btn_s2[gi] == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_stable <= r_btn_s2[gi];
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
            end

            assign w_stable[gi] = r_stable;
            assign w_rise[gi]   = r_stable & ~r_stable_d;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load FSM with registered outputs
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [3:0] r_data_word;
    logic [2:0] r_err_pos;
    logic       r_load_pulse;
    logic       r_busy;

    // Capture the switches on an accepted press, then wait for release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_data_word  <= '0;
            r_err_pos    <= '0;
            r_load_pulse <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_load_pulse <= 1'b0;
                    r_busy       <= 1'b0;
                    if (w_rise[c_BTN_LOAD]) begin
                        // Registers load on entry so the strobe and the new
                        // values appear together in the CAPTURE cycle.
                        r_state      <= S_CAPTURE;
                        r_data_word  <= r_data_s2;
                        r_err_pos    <= r_err_s2;
                        r_load_pulse <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_load_pulse <= 1'b0;
                    r_busy       <= 1'b1;
                    r_state      <= S_HOLD;
                end
                S_HOLD: begin
                    r_load_pulse <= 1'b0;
                    if (!w_stable[c_BTN_LOAD]) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_load_pulse <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display select toggle
    // ------------------------------------------------------------------
    logic r_disp_sel;

    // Flip the display source on every accepted select press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_disp_sel <= 1'b0;
        end else if (w_rise[c_BTN_SEL]) begin
            r_disp_sel <= ~r_disp_sel;
        end
    end

    assign data_word  = r_data_word;
    assign err_pos    = r_err_pos;
    assign load_pulse = r_load_pulse;
    assign disp_sel   = r_disp_sel;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_hamming_input_capture.sv
// ============================================================================
// Module      : tb_hamming_input_capture
// Description : Self-checking bench for hamming_input_capture with
//               DEBOUNCE_CYCLES=4. Expected load strobes and display-select
//               changes are queued by the stimulus and consumed by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_input_capture;

    localparam int c_DB = 4;
    // Raw button edge to registered output: 2 sync + c_DB debounce + 1 FSM.
    localparam int c_LAT = c_DB + 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_data;
    logic [2:0] sw_err;
    logic       btn_load;
    logic       btn_sel;
    logic [3:0] data_word;
    logic [2:0] err_pos;
    logic       load_pulse;
    logic       disp_sel;
    logic       busy;

    hamming_input_capture #(
        .DEBOUNCE_CYCLES(c_DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_data   (sw_data),
        .sw_err    (sw_err),
        .btn_load  (btn_load),
        .btn_sel   (btn_sel),
        .data_word (data_word),
        .err_pos   (err_pos),
        .load_pulse(load_pulse),
        .disp_sel  (disp_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] d;
        logic [2:0] e;
    } load_t;

    typedef struct {
        int   at;
        logic v;
    } disp_t;

    load_t lq[$];
    disp_t dq[$];

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    logic prev_disp = 1'b0;
    logic model_disp = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to just after the rising edge that brings cyc to c.
    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every strobe and every disp_sel change must match a queued
    // expectation, including the cycle it arrives in.
    initial begin
        load_t lx;
        disp_t dx;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (load_pulse === 1'b1) begin
                    if (lq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_load_pulse: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        lx = lq.pop_front();
                        chk("load_cycle", cyc, lx.at);
                        chk("load_data",  int'(data_word), int'(lx.d));
                        chk("load_err",   int'(err_pos),   int'(lx.e));
                    end
                end
                if (disp_sel !== prev_disp) begin
                    if (dq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_disp_change: got %0d expected %0d (cycle %0d)",
                                 disp_sel, prev_disp, cyc);
                    end else begin
                        dx = dq.pop_front();
                        chk("disp_cycle", cyc, dx.at);
                        chk("disp_value", int'(disp_sel), int'(dx.v));
                    end
                    prev_disp = disp_sel;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int r;

        // ---------------- reset with every input high ----------------
        rst_n    = 1'b0;
        sw_data  = 4'hF;
        sw_err   = 3'h7;
        btn_load = 1'b1;
        btn_sel  = 1'b1;
        step_to(3);
        chk("rst_data_word",  int'(data_word),  0);
        chk("rst_err_pos",    int'(err_pos),    0);
        chk("rst_load_pulse", int'(load_pulse), 0);
        chk("rst_disp_sel",   int'(disp_sel),   0);
        chk("rst_busy",       int'(busy),       0);
        prev_disp = 1'b0;
        mon_en    = 1'b1;

        // Buttons held through reset release count as fresh presses.
        t = cyc;
        rst_n = 1'b1;
        lq.push_back('{t + c_LAT, 4'hF, 3'h7});
        model_disp = ~model_disp;
        dq.push_back('{t + c_LAT, model_disp});
        step_to(t + c_LAT);
        chk("busy_in_capture", int'(busy), 0);
        step_to(t + c_LAT + 1);
        chk("busy_in_hold", int'(busy), 1);

        // Release: busy must hold until the release is debounced.
        step_to(t + 10);
        t = cyc;
        btn_load = 1'b0;
        btn_sel  = 1'b0;
        step_to(t + c_LAT - 1);
        chk("busy_before_release", int'(busy), 1);
        step_to(t + c_LAT);
        chk("busy_after_release", int'(busy), 0);
        step_to(t + 12);

        // ---------------- clean press ----------------
        t = cyc;
        sw_data  = 4'hA;
        sw_err   = 3'd5;
        btn_load = 1'b1;
        lq.push_back('{t + c_LAT, 4'hA, 3'd5});
        step_to(t + c_LAT + 1);
        chk("clean_busy", int'(busy), 1);

        // Switch changes while held are ignored.
        sw_data = 4'hC;
        sw_err  = 3'd2;
        step_to(t + 20);
        chk("hold_data_kept", int'(data_word), 'hA);
        chk("hold_err_kept",  int'(err_pos),   5);
        t = cyc;
        btn_load = 1'b0;
        step_to(t + 12);
        chk("idle_after_release", int'(busy), 0);

        // Second press picks up the changed switches.
        t = cyc;
        btn_load = 1'b1;
        lq.push_back('{t + c_LAT, 4'hC, 3'd2});
        step_to(t + 10);
        chk("second_data", int'(data_word), 'hC);
        t = cyc;
        btn_load = 1'b0;
        step_to(t + 12);

        // ---------------- bouncy press ----------------
        sw_data = 4'h6;
        sw_err  = 3'd1;
        t = cyc;
        btn_load = 1'b1; step_to(t + 2);
        btn_load = 1'b0; step_to(t + 4);
        btn_load = 1'b1; step_to(t + 6);
        btn_load = 1'b0; step_to(t + 8);
        t = cyc;
        btn_load = 1'b1;
        lq.push_back('{t + c_LAT, 4'h6, 3'd1});
        step_to(t + 12);
        t = cyc;
        btn_load = 1'b0;
        step_to(t + 12);

        // ---------------- select presses ----------------
        for (int k = 0; k < 3; k++) begin
            t = cyc;
            btn_sel = 1'b1;
            model_disp = ~model_disp;
            dq.push_back('{t + c_LAT, model_disp});
            step_to(t + 10);
            btn_sel = 1'b0;
            step_to(t + 20);
        end

        // A 3-cycle glitch is shorter than the debounce window.
        t = cyc;
        btn_sel = 1'b1;
        step_to(t + 3);
        btn_sel = 1'b0;
        step_to(t + 15);
        chk("glitch_no_toggle", int'(disp_sel), int'(model_disp));

        // One more press so disp_sel is 1 going into the reset test.
        t = cyc;
        btn_sel = 1'b1;
        model_disp = ~model_disp;
        dq.push_back('{t + c_LAT, model_disp});
        step_to(t + 10);
        btn_sel = 1'b0;
        step_to(t + 20);

        // ---------------- reset while in HOLD ----------------
        t = cyc;
        sw_data  = 4'h9;
        sw_err   = 3'd4;
        btn_load = 1'b1;
        lq.push_back('{t + c_LAT, 4'h9, 3'd4});
        step_to(t + 12);
        chk("pre_reset_busy", int'(busy),     1);
        chk("pre_reset_disp", int'(disp_sel), 1);
        r = cyc;
        rst_n = 1'b0;
        model_disp = 1'b0;
        dq.push_back('{r + 1, 1'b0});
        step_to(r + 1);
        chk("midrst_busy",  int'(busy),       0);
        chk("midrst_disp",  int'(disp_sel),   0);
        chk("midrst_data",  int'(data_word),  0);
        chk("midrst_err",   int'(err_pos),    0);
        chk("midrst_pulse", int'(load_pulse), 0);
        step_to(r + 4);
        sw_data = 4'h5;
        sw_err  = 3'd3;
        r = cyc;
        rst_n = 1'b1;
        lq.push_back('{r + c_LAT, 4'h5, 3'd3});
        step_to(r + c_LAT - 1);
        chk("post_rst_no_early_pulse", int'(load_pulse), 0);
        step_to(r + 10);
        chk("post_rst_busy", int'(busy),      1);
        chk("post_rst_data", int'(data_word), 5);
        t = cyc;
        btn_load = 1'b0;
        step_to(t + 12);

        // Every queued expectation must have been consumed.
        chk("load_queue_empty", lq.size(), 0);
        chk("disp_queue_empty", dq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
